// File: rtl/io_bus_arbiter.sv
// Two-master round-robin bus arbiter with a burst cap, placed in front of io_ram_datapath.
// The granted master drives the datapath bus; load data is registered and returned to its issuer.
module io_bus_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic        m0_we,
    input  logic [1:0]  m0_mem_ctrl,
    output logic        m0_gnt,
    output logic [31:0] m0_rd,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic        m1_we,
    input  logic [1:0]  m1_mem_ctrl,
    output logic        m1_gnt,
    output logic [31:0] m1_rd,
    output logic        m1_rvalid,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wd,
    output logic        bus_we,
    output logic [1:0]  bus_mem_ctrl,
    input  logic [31:0] bus_rd
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_owner, last_owner_nxt;
    logic             beat0, beat1;

    assign m0_gnt = (state == OWN0);
    assign m1_gnt = (state == OWN1);
    assign beat0  = m0_gnt & m0_req;
    assign beat1  = m1_gnt & m1_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        unique case (state)
            IDLE: begin
                if (m0_req && m1_req) state_nxt = last_owner ? OWN0 : OWN1;
                else if (m0_req)      state_nxt = OWN0;
                else if (m1_req)      state_nxt = OWN1;
            end
            OWN0: begin
                if (!m0_req)                      state_nxt = m1_req ? OWN1 : IDLE;
                else if (m1_req && cnt == CNT_MAX) state_nxt = OWN1;
            end
            OWN1: begin
                if (!m1_req)                      state_nxt = m0_req ? OWN0 : IDLE;
                else if (m0_req && cnt == CNT_MAX) state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase

        if (state == OWN0 && state_nxt != OWN0) last_owner_nxt = 1'b0;
        if (state == OWN1 && state_nxt != OWN1) last_owner_nxt = 1'b1;

        // Count beats of the current tenure; hold at the cap while the other side is quiet.
        if (state_nxt != state)                   cnt_nxt = '0;
        else if ((beat0 || beat1) && cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
    end

    always_comb begin
        bus_address  = '0;
        bus_wd       = '0;
        bus_we       = 1'b0;
        bus_mem_ctrl = '0;
        unique case (state)
            OWN0: begin
                bus_address  = m0_addr;
                bus_wd       = m0_wd;
                bus_we       = m0_we & m0_req;
                bus_mem_ctrl = m0_mem_ctrl;
            end
            OWN1: begin
                bus_address  = m1_addr;
                bus_wd       = m1_wd;
                bus_we       = m1_we & m1_req;
                bus_mem_ctrl = m1_mem_ctrl;
            end
            default: ;
        endcase
    end

    // Load data is tagged by the beat's issuer, so a handover on the same edge cannot misroute it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m0_rd     <= '0;
            m0_rvalid <= 1'b0;
            m1_rd     <= '0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= beat0 & ~m0_we;
            m1_rvalid <= beat1 & ~m1_we;
            if (beat0 && !m0_we) m0_rd <= bus_rd;
            if (beat1 && !m1_we) m1_rd <= bus_rd;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic compared against a transaction-level reference model.
module tb_io_bus_arbiter;

    localparam int MAX_BURST = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic [1:0]  m0_mem_ctrl, m1_mem_ctrl;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rd, m1_rd;
    logic [31:0] bus_address, bus_wd, bus_rd;
    logic        bus_we;
    logic [1:0]  bus_mem_ctrl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_we(m0_we),
        .m0_mem_ctrl(m0_mem_ctrl), .m0_gnt(m0_gnt), .m0_rd(m0_rd), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_we(m1_we),
        .m1_mem_ctrl(m1_mem_ctrl), .m1_gnt(m1_gnt), .m1_rd(m1_rd), .m1_rvalid(m1_rvalid),
        .bus_address(bus_address), .bus_wd(bus_wd), .bus_we(bus_we),
        .bus_mem_ctrl(bus_mem_ctrl), .bus_rd(bus_rd)
    );

    // Stand-in datapath: 64-word RAM whose unwritten words read as a known pattern.
    logic [31:0] ram [64];
    bit          written [64];

    function automatic logic [31:0] init_word(input int idx);
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    assign bus_rd = written[bus_address[7:2]] ? ram[bus_address[7:2]] : init_word(int'(bus_address[7:2]));

    always @(posedge clk) begin
        if (bus_we === 1'b1) begin
            ram[bus_address[7:2]]     <= bus_wd;
            written[bus_address[7:2]] <= 1'b1;
        end
    end

    // Reference model: owner (-1 none), beats in current tenure, last owner, return regs, memory image.
    int          m_own, m_cnt, m_last;
    logic [31:0] m_rd [2];
    bit          m_rv [2];
    logic [31:0] m_mem [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_cnt = 0; m_last = 1;
        m_rd[0] = '0; m_rd[1] = '0; m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    endtask

    task automatic model_compare();
        logic [31:0] ea, ed;
        logic [1:0]  ec;
        logic        ew;
        ea = '0; ed = '0; ec = '0; ew = 1'b0;
        if (m_own == 0) begin
            ea = m0_addr; ed = m0_wd; ec = m0_mem_ctrl; ew = m0_we & m0_req;
        end else if (m_own == 1) begin
            ea = m1_addr; ed = m1_wd; ec = m1_mem_ctrl; ew = m1_we & m1_req;
        end
        check("m0_gnt", 32'(m0_gnt), 32'(m_own == 0));
        check("m1_gnt", 32'(m1_gnt), 32'(m_own == 1));
        check("m0_rvalid", 32'(m0_rvalid), 32'(m_rv[0]));
        check("m1_rvalid", 32'(m1_rvalid), 32'(m_rv[1]));
        check("m0_rd", m0_rd, m_rd[0]);
        check("m1_rd", m1_rd, m_rd[1]);
        check("bus_address", bus_address, ea);
        check("bus_wd", bus_wd, ed);
        check("bus_we", 32'(bus_we), 32'(ew));
        check("bus_mem_ctrl", 32'(bus_mem_ctrl), 32'(ec));
        check("gnt_overlap", 32'(m0_gnt & m1_gnt), 32'd0);
    endtask

    task automatic model_advance();
        logic        r [2];
        logic        w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic        beat;
        int          nxt, o;
        r[0] = m0_req; w[0] = m0_we; a[0] = m0_addr; d[0] = m0_wd;
        r[1] = m1_req; w[1] = m1_we; a[1] = m1_addr; d[1] = m1_wd;
        o    = m_own;
        beat = 1'b0;
        if (o >= 0) beat = r[o];
        if (beat && w[o]) m_mem[a[o][7:2]] = d[o];
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        if (beat && !w[o]) begin
            m_rd[o] = m_mem[a[o][7:2]];
            m_rv[o] = 1'b1;
        end
        if (o < 0) begin
            if (r[0] && r[1]) nxt = 1 - m_last;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
            else              nxt = -1;
        end else if (!r[o]) begin
            nxt = r[1-o] ? 1 - o : -1;
        end else if (r[1-o] && m_cnt + 1 >= MAX_BURST) begin
            nxt = 1 - o;
        end else begin
            nxt = o;
        end
        if (nxt != o) begin
            if (o >= 0) m_last = o;
            m_cnt = 0;
        end else if (beat) begin
            m_cnt = (m_cnt + 1 > MAX_BURST - 1) ? MAX_BURST - 1 : m_cnt + 1;
        end
        m_own = nxt;
    endtask

    task automatic sample();
        @(negedge clk);
        model_compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    typedef struct {
        bit rst_n;
        bit r0;
        bit r1;
        bit e_g0;
        bit e_g1;
    } vec_t;

    vec_t vecs [17];

    initial begin
        bit e_g0, e_g1;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
        model_reset();

        // Reset with random master inputs on the bus side.
        rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'($urandom); m0_addr = $urandom; m0_wd = $urandom; m0_mem_ctrl = 2'($urandom);
        m1_req = 1'b1; m1_we = 1'($urandom); m1_addr = $urandom; m1_wd = $urandom; m1_mem_ctrl = 2'($urandom);
        tick();

        // Directed vector table: reset, first tie, handovers without bubbles, round-robin ties.
        for (int i = 0; i < 17; i++) begin
            rst_n  = vecs[i].rst_n;
            m0_req = vecs[i].r0;
            m1_req = vecs[i].r1;
            if (vecs[i].rst_n) begin
                m0_we = 1'b0; m0_addr = 32'h20; m0_wd = 32'h0; m0_mem_ctrl = 2'd2;
                m1_we = 1'b0; m1_addr = 32'h30; m1_wd = 32'h0; m1_mem_ctrl = 2'd2;
            end
            sample();
            check($sformatf("vec%0d_m0_gnt", i), 32'(m0_gnt), 32'(vecs[i].e_g0));
            check($sformatf("vec%0d_m1_gnt", i), 32'(m1_gnt), 32'(vecs[i].e_g1));
            if (!vecs[i].rst_n) begin
                check($sformatf("vec%0d_bus_we", i), 32'(bus_we), 32'd0);
                check($sformatf("vec%0d_bus_address", i), bus_address, 32'd0);
            end
            tick();
        end

        // m0 alone: store 0xA5 to 0x10, then load it back.
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wd = 32'hA5; m0_mem_ctrl = 2'd2;
        sample();
        check("st_c1_m0_gnt", 32'(m0_gnt), 32'd0);
        check("st_c1_bus_we", 32'(bus_we), 32'd0);
        tick();
        sample();
        check("st_c2_m0_gnt", 32'(m0_gnt), 32'd1);
        check("st_c2_bus_we", 32'(bus_we), 32'd1);
        check("st_c2_bus_address", bus_address, 32'h10);
        tick();
        m0_we = 1'b0;
        sample();
        check("ld_c3_bus_we", 32'(bus_we), 32'd0);
        tick();
        m0_req = 1'b0;
        sample();
        check("ld_c4_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("ld_c4_m0_rd", m0_rd, 32'h0000_00A5);
        check("ld_c4_bus_we", 32'(bus_we), 32'd0);
        tick();
        sample();
        check("ld_c5_m0_rvalid", 32'(m0_rvalid), 32'd0);
        tick();

        // Burst cap: m0 stores for 20 beats while m1 keeps loading.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h80; m0_wd = $urandom;
        m1_we = 1'b0; m1_addr = 32'h40; m1_mem_ctrl = 2'd2;
        sample();
        check("burst_k0_m0_gnt", 32'(m0_gnt), 32'd0);
        tick();
        m1_req = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            e_g0 = (((k - 1) / MAX_BURST) % 2) == 0;
            e_g1 = !e_g0;
            sample();
            check($sformatf("burst_k%0d_m0_gnt", k), 32'(m0_gnt), 32'(e_g0));
            check($sformatf("burst_k%0d_m1_gnt", k), 32'(m1_gnt), 32'(e_g1));
            check($sformatf("burst_k%0d_m0_rvalid", k), 32'(m0_rvalid), 32'd0);
            if (k == 17) begin
                check("handover_m1_rvalid", 32'(m1_rvalid), 32'd1);
                check("handover_m1_rd", m1_rd, 32'hC0DE_0010);
            end
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        sample(); tick();
        sample(); tick();

        // Reset in the middle of an m1 burst drops the pending load return.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
        sample(); tick();
        sample(); tick();
        rst_n = 1'b0;
        sample();
        check("rst_mid_m1_gnt", 32'(m1_gnt), 32'd1);
        check("rst_mid_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("rst_mid_m1_rd", m1_rd, 32'hC0DE_0011);
        tick();
        rst_n = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h48;
        sample();
        check("rst_after_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_after_m1_gnt", 32'(m1_gnt), 32'd0);
        check("rst_after_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("rst_after_m0_rvalid", 32'(m0_rvalid), 32'd0);
        tick();
        sample();
        check("rst_tie_m0_gnt", 32'(m0_gnt), 32'd1);
        check("rst_tie_m1_gnt", 32'(m1_gnt), 32'd0);
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        sample(); tick();
        sample(); tick();

        // Random traffic; a waiting master keeps its request and payload stable.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(63) != 0);
            if (!(m0_req && m_own != 0)) begin
                m0_req = ($urandom_range(3) != 0); m0_we = 1'($urandom);
                m0_addr = 32'($urandom_range(255)); m0_wd = $urandom; m0_mem_ctrl = 2'($urandom);
            end
            if (!(m1_req && m_own != 1)) begin
                m1_req = ($urandom_range(3) != 0); m1_we = 1'($urandom);
                m1_addr = 32'($urandom_range(255)); m1_wd = $urandom; m1_mem_ctrl = 2'($urandom);
            end
            sample();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
